// File: rtl/time_uart_tx.sv
// time_uart_tx: sends the current BCD time as an ASCII line "HH:MM:SS" plus a line ending on an 8N1 UART pin.
// Latency: a request seen in cycle N gives LOAD in N+1 and the start bit from edge N+2; each character takes 10*DIV cycles.
// Backpressure: none; requests that arrive during a line merge into one pending line, which carries the time latched at its own LOAD.
//
// Ports:
//   clk, rst_n                      system clock and asynchronous active-low reset
//   clock_hour/minute/second [7:0]  packed BCD time from the clock core
//   trig                            one-cycle request to send the time even if it has not changed
//   uart_tx                         serial line (idles high)
//   busy                            high while a line is being sent
//   done                            one-cycle pulse after the final stop bit
// Build option: define TIME_TX_CRLF_EN to end the line with CR LF (10 chars); otherwise LF only (9 chars).
module time_uart_tx #(
  parameter int CLK_FREQ = 50_000_000,
  parameter int BAUD     = 115200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] clock_hour,
  input  logic [7:0] clock_minute,
  input  logic [7:0] clock_second,
  input  logic       trig,
  output logic       uart_tx,
  output logic       busy,
  output logic       done
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DIV - 1);

`ifdef TIME_TX_CRLF_EN
  localparam logic [3:0] LAST_CHAR = 4'd9;
`else
  localparam logic [3:0] LAST_CHAR = 4'd8;
`endif

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t        state;
  logic [7:0]    prev_sec;
  logic          pending;
  logic [7:0]    snap_h;
  logic [7:0]    snap_m;
  logic [7:0]    snap_s;
  logic [3:0]    char_idx;
  logic [2:0]    bit_idx;
  logic [CW-1:0] cnt;
  logic          req;
  logic [7:0]    cur_char;

  // A new second or an explicit trigger both count as one request.
  assign req = (clock_second != prev_sec) || trig;

  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
  endfunction

  // Pick the character being sent from the frozen snapshot.
  always_comb begin
    cur_char = 8'h0A;
    case (char_idx)
      4'd0: cur_char = digit_ascii(snap_h[7:4]);
      4'd1: cur_char = digit_ascii(snap_h[3:0]);
      4'd2: cur_char = 8'h3A;
      4'd3: cur_char = digit_ascii(snap_m[7:4]);
      4'd4: cur_char = digit_ascii(snap_m[3:0]);
      4'd5: cur_char = 8'h3A;
      4'd6: cur_char = digit_ascii(snap_s[7:4]);
      4'd7: cur_char = digit_ascii(snap_s[3:0]);
`ifdef TIME_TX_CRLF_EN
      4'd8: cur_char = 8'h0D;
`else
      4'd8: cur_char = 8'h0A;
`endif
      default: cur_char = 8'h0A;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      prev_sec <= 8'hFF;
      pending  <= 1'b0;
      snap_h   <= 8'h00;
      snap_m   <= 8'h00;
      snap_s   <= 8'h00;
      char_idx <= 4'd0;
      bit_idx  <= 3'd0;
      cnt      <= '0;
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      prev_sec <= clock_second;
      done     <= 1'b0;
      if (req) pending <= 1'b1;

      case (state)
        // Accepting the raw request here saves a cycle, so LOAD happens
        // in the same cycle that pending becomes set.
        S_IDLE: begin
          if (pending || req) state <= S_LOAD;
        end

        // The output is registered, so the start bit is driven here and
        // appears on the edge that enters START.
        S_LOAD: begin
          snap_h   <= clock_hour;
          snap_m   <= clock_minute;
          snap_s   <= clock_second;
          pending  <= req;
          char_idx <= 4'd0;
          cnt      <= '0;
          uart_tx  <= 1'b0;
          busy     <= 1'b1;
          state    <= S_START;
        end

        S_START: begin
          if (cnt == CNT_LAST) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            uart_tx <= cur_char[0];
            state   <= S_DATA;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (bit_idx == 3'd7) begin
              uart_tx <= 1'b1;
              state   <= S_STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              uart_tx <= cur_char[bit_idx + 3'd1];
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // The next start bit follows straight after the stop bit, so there is
        // no idle gap between characters.
        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (char_idx == LAST_CHAR) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              char_idx <= char_idx + 4'd1;
              uart_tx  <= 1'b0;
              state    <= S_START;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_time_uart_tx.sv
module tb_time_uart_tx;

  localparam int CLK_FREQ = 16;
  localparam int BAUD     = 1;
  localparam int DIV      = CLK_FREQ / BAUD;
`ifdef TIME_TX_CRLF_EN
  localparam int CHARS = 10;
`else
  localparam int CHARS = 9;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] clock_hour = 8'h00;
  logic [7:0] clock_minute = 8'h00;
  logic [7:0] clock_second = 8'h00;
  logic       trig = 1'b0;
  logic       uart_tx;
  logic       busy;
  logic       done;

  int         tests = 0;
  int         fails = 0;
  int         cyc = 0;
  logic [7:0] exp_q[$];
  logic       rst_seen = 1'b0;

  time_uart_tx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clock_hour  (clock_hour),
    .clock_minute(clock_minute),
    .clock_second(clock_second),
    .trig        (trig),
    .uart_tx     (uart_tx),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge rst_n) rst_seen = 1'b1;

  task automatic chk(input string nm, input int act, input int req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h) at cycle %0d", nm, act, act, req, req, cyc);
    end
  endtask

  // Reference model: one text line per request, from the time it latched.
  function automatic logic [7:0] asc(input logic [3:0] n);
    if (n < 4'd10) return 8'd48 + {4'd0, n};
    return 8'd63;
  endfunction

  task automatic push_line(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    exp_q.push_back(asc(h[7:4]));
    exp_q.push_back(asc(h[3:0]));
    exp_q.push_back(8'd58);
    exp_q.push_back(asc(m[7:4]));
    exp_q.push_back(asc(m[3:0]));
    exp_q.push_back(8'd58);
    exp_q.push_back(asc(s[7:4]));
    exp_q.push_back(asc(s[3:0]));
`ifdef TIME_TX_CRLF_EN
    exp_q.push_back(8'h0D);
`endif
    exp_q.push_back(8'h0A);
  endtask

  // Monitor: decodes 8N1 frames at bit centres and checks them against the scoreboard.
  initial begin : monitor
    int         t;
    int         k;
    int         active;
    int         nbytes;
    int         lstart;
    logic       prev_done;
    logic [7:0] sh;
    t = 0; active = 0; nbytes = 0; lstart = 0; prev_done = 1'b0; sh = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst_n || rst_seen) begin
        rst_seen = 1'b0;
        active = 0;
        nbytes = 0;
        prev_done = 1'b0;
        continue;
      end
      if (done) begin
        chk("done_single_cycle", int'(prev_done), 0);
        chk("line_char_count", nbytes, CHARS);
        chk("line_cycles", cyc - lstart, CHARS * 10 * DIV);
        chk("busy_low_at_done", int'(busy), 0);
        nbytes = 0;
      end
      prev_done = done;
      if (active == 0) begin
        if (uart_tx == 1'b0) begin
          active = 1;
          t = 0;
          if (nbytes == 0) lstart = cyc;
          chk("busy_in_frame", int'(busy), 1);
        end
      end else begin
        t++;
        if ((t % DIV) == (DIV / 2)) begin
          k = t / DIV;
          if (k == 0) begin
            chk("start_bit", int'(uart_tx), 0);
          end else if (k <= 8) begin
            sh[k-1] = uart_tx;
          end else begin
            chk("stop_bit", int'(uart_tx), 1);
            nbytes++;
            active = 0;
            if (exp_q.size() == 0) begin
              tests++;
              fails++;
              $display("FAIL unexpected_byte actual=0x%0h required=no byte", sh);
            end else begin
              chk("line_byte", int'(sh), int'(exp_q.pop_front()));
            end
          end
        end
      end
    end
  end

  task automatic wait_start(input string nm, output int s);
    s = -1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (rst_n && uart_tx == 1'b0) begin
        s = cyc;
        break;
      end
    end
    if (s < 0) begin
      tests++;
      fails++;
      $display("FAIL %s_start_timeout actual=no start bit required=start bit", nm);
    end
  endtask

  task automatic wait_done(input string nm, output int d);
    d = -1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      if (done) begin
        d = cyc;
        break;
      end
    end
    if (d < 0) begin
      tests++;
      fails++;
      $display("FAIL %s_done_timeout actual=no done required=done pulse", nm);
    end
  endtask

  task automatic quiet(input string nm, input int n);
    int lows;
    lows = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (uart_tx == 1'b0) lows++;
    end
    chk(nm, lows, 0);
  endtask

  // Drive a new time (and optionally trig) in one cycle, expect one line 2 cycles later.
  task automatic send(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s,
                      input logic tr, input string nm);
    int c;
    int st;
    int d;
    @(posedge clk);
    #1;
    clock_hour = h;
    clock_minute = m;
    clock_second = s;
    trig = tr;
    c = cyc;
    push_line(h, m, s);
    if (tr) begin
      @(posedge clk);
      #1;
      trig = 1'b0;
    end
    wait_start(nm, st);
    if (st >= 0) chk({nm, "_latency"}, st - c, 2);
    wait_done(nm, d);
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=still running required=finished");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int         st;
    int         d;
    int         c;
    int         mode;
    logic [7:0] rh;
    logic [7:0] rm;
    logic [7:0] rs;
    logic       rt;

    // Reset values, then the power-on line of 00:00:00.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_uart_tx", int'(uart_tx), 1);
    chk("reset_busy", int'(busy), 0);
    chk("reset_done", int'(done), 0);
    push_line(8'h00, 8'h00, 8'h00);
    rst_n = 1'b1;
    wait_start("por", st);
    wait_done("por", d);
    quiet("quiet_after_por", 20);

    // Idle at 23:59:58, then the second ticks to 59.
    send(8'h23, 8'h59, 8'h58, 1'b0, "set_235958");
    quiet("quiet_after_set", 20);
    send(8'h23, 8'h59, 8'h59, 1'b0, "tick_235959");
    quiet("quiet_after_tick", 20);

    // Three second changes during one line coalesce into one more line.
    @(posedge clk);
    #1;
    clock_second = 8'h00;
    c = cyc;
    push_line(8'h23, 8'h59, 8'h00);
    push_line(8'h23, 8'h59, 8'h03);
    wait_start("coal_first", st);
    if (st >= 0) chk("coal_first_latency", st - c, 2);
    repeat (200) @(posedge clk);
    #1 clock_second = 8'h01;
    repeat (400) @(posedge clk);
    #1 clock_second = 8'h02;
    repeat (400) @(posedge clk);
    #1 clock_second = 8'h03;
    wait_done("coal_first", d);
    wait_start("coal_second", st);
    if (st >= 0 && d >= 0) chk("coal_gap", st - d, 2);
    wait_done("coal_second", d);
    quiet("quiet_after_coalesce", 300);

    // Non-decimal hour nibble with a trig-only request.
    send(8'h1A, 8'h59, 8'h03, 1'b1, "trig_1a");
    quiet("quiet_after_trig", 30);

    // Random times and request kinds.
    for (int i = 0; i < 6; i++) begin
      rh = 8'($urandom_range(0, 255));
      rm = 8'($urandom_range(0, 255));
      rs = 8'($urandom_range(0, 255));
      mode = $urandom_range(0, 2);
      if (mode == 2) begin
        rs = clock_second;
        rt = 1'b1;
      end else begin
        if (rs == clock_second) rs = rs ^ 8'h01;
        rt = (mode == 1);
      end
      send(rh, rm, rs, rt, $sformatf("rand%0d", i));
      quiet($sformatf("quiet_rand%0d", i), 30);
    end

    // Reset pulled in the middle of the first data bit of a line.
    send_prep: begin
      @(posedge clk);
      #1;
      clock_hour = 8'h05;
      clock_minute = 8'h07;
      clock_second = 8'h09;
      trig = 1'b1;
      push_line(8'h05, 8'h07, 8'h09);
      @(posedge clk);
      #1;
      trig = 1'b0;
    end
    wait_start("rst_mid", st);
    while (cyc < st + DIV + DIV / 2) @(negedge clk);
    chk("mid_bit_low", int'(uart_tx), 0);
    chk("mid_busy_high", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_uart_tx", int'(uart_tx), 1);
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(done), 0);
    exp_q.delete();
    push_line(8'h05, 8'h07, 8'h09);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_start("after_reset", st);
    wait_done("after_reset", d);
    quiet("quiet_end", 100);

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/time_uart_tx.md
# time_uart_tx

Serial time reporter for the digital clock. Snapshots the packed-BCD `clock_hour`/`clock_minute`/`clock_second` from the clock core and transmits them as an ASCII line "HH:MM:SS" plus line ending over a 8N1 UART pin. This is the outbound path of the clock: keys set the time in, this block reports it out. It sits in the top level beside the display, driven by the system clock and system reset.

## Interface
- `CLK_FREQ`, 50_000_000, system clock frequency in Hz
- `BAUD`, 115200, line rate in bit/s; bit period `DIV = CLK_FREQ/BAUD` cycles, integer division truncating, `DIV >= 2`
- `clk`  in  1  system clock, all state on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `clock_hour`  in  8  packed BCD hour, tens in [7:4], units in [3:0]
- `clock_minute`  in  8  packed BCD minute
- `clock_second`  in  8  packed BCD second
- `trig`  in  1  one-cycle request to send the current time regardless of change
- `uart_tx`  out  1  serial line, idle high
- `busy`  out  1  high while a line is in flight
- `done`  out  1  one-cycle pulse when the last stop bit of a line completes

## Operation
- Reset values: `uart_tx`=1, `busy`=0, `done`=0. Internal `prev_sec`=8'hFF, `pending`=0, FSM in IDLE.
- Request: `pending` is set in any cycle where `clock_second != prev_sec` or `trig`=1. `prev_sec` is updated to `clock_second` every cycle. Because `prev_sec` resets to 8'hFF, the first cycle after reset always raises a request.
- FSM states:
  - IDLE: if `pending`, go to LOAD.
  - LOAD: latch all three inputs into a snapshot, clear `pending`, set char index to 0, go to START.
  - START: `uart_tx`=0 for DIV cycles, then go to DATA.
  - DATA: 8 bits LSB first, DIV cycles each, then go to STOP.
  - STOP: `uart_tx`=1 for DIV cycles. Then go to START with the index incremented if characters remain. Otherwise pulse `done` and go to IDLE.
- Character order: H-tens, H-units, ':', M-tens, M-units, ':', S-tens, S-units, then the line ending.
- ASCII conversion: digit d in 0..9 becomes 8'h30+d. A nibble in A..F becomes '?' (8'h3F). ':' is 8'h3A.
- The snapshot is frozen for the whole line. Input changes during a line only set `pending`, and multiple requests coalesce into one. The next line uses values latched at its own LOAD, so it carries the newest time.
- `trig` and a second change in the same cycle produce one request.
- Reset asserted mid-line: outputs return to reset values immediately (asynchronous), and the partial line is abandoned. After release, a full new line is sent.

## Timing
- Request raised on cycle N sets `pending` at edge N+1. LOAD occurs on cycle N+1, and `busy`=1 with `uart_tx`=0 from edge N+2.
- Each character lasts 10·DIV cycles, with no idle gap between characters.
- Line length is `chars`·10·DIV cycles, measured from the first start-bit edge to the `done` edge.
- `done` is high for exactly one cycle, the cycle after the final stop bit. `busy` falls on that same edge.
- If `pending` is set at that point, LOAD follows on the next cycle, so lines are separated by exactly 1 IDLE cycle plus 1 LOAD cycle of `uart_tx`=1.

## Configuration
- `TIME_TX_CRLF_EN` defined: the line ends in CR LF (8'h0D, 8'h0A), giving 10 characters.
- `TIME_TX_CRLF_EN` undefined: the line ends in LF only, giving 9 characters.
- The FSM, baud timing and everything else are identical in both builds.

## Test plan
Bench parameters are `CLK_FREQ`=16, `BAUD`=1 (DIV=16), with the macro defined unless stated.
- Reset held, then released with inputs 8'h00/8'h00/8'h00:
  - during reset, `uart_tx`=1, `busy`=0, `done`=0;
  - the decoded bytes are 30 30 3A 30 30 3A 30 30 0D 0A;
  - `done` fires 1600 cycles after the first start edge.
- Idle at 23:59:58, then `clock_second` changes to 8'h59: start bit begins 2 cycles later, and the bytes are 32 33 3A 35 39 3A 35 39 0D 0A.
- `clock_second` changes 3 times during one line: exactly one further line follows, starting 2 cycles after `done`, and it carries the last value.
- `clock_hour`=8'h1A with `trig` pulsed: the first two bytes are 31 3F.
- `rst_n` pulled low in the middle of a data bit:
  - `uart_tx` goes to 1 and `busy` to 0 without waiting for a clock edge;
  - after release, a complete line is sent.
- Macro undefined: 9 bytes, the last is 0A, and `done` fires 1440 cycles after the first start edge.
